sp_ram_ctrl: RTL

Parametrised single-port SRAM controller: one behavioural or macro-backed DW x DEPTH array behind a valid/ready request channel with byte-masked writes and a valid/ready read-response channel. The response channel is backpressure-safe. Read data leaving the array is captured in an internal skid FIFO, so a stalled consumer never loses data and never forces a re-read. It replaces fixed-size single-port wrappers wherever a core or DMA engine needs flow-controlled scratchpad access.

---
 rtl/sp_ram_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/sp_ram_ctrl.sv
// sp_ram_ctrl: single-port SRAM behind a valid/ready request channel with
// byte-masked writes and a backpressure-safe valid/ready read response.
// Read data is parked in a first-word-fall-through skid FIFO whose depth
// equals the read latency L, so a stalled consumer never loses data.
// Optional feature: define RAM_OREG_EN to add a registered array output
// stage (read latency 2, skid depth 2); otherwise latency and depth are 1.
module sp_ram_ctrl #(
  parameter int DW    = 32,
  parameter int DEPTH = 128,
  localparam int AW   = $clog2(DEPTH),
  localparam int BW   = DW / 8
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          req_valid,
  output logic          req_ready,
  input  logic          req_we,
  input  logic [AW-1:0] req_addr,
  input  logic [DW-1:0] req_wdata,
  input  logic [BW-1:0] req_be,
  output logic          rsp_valid,
  input  logic          rsp_ready,
  output logic [DW-1:0] rsp_rdata
);

`ifdef RAM_OREG_EN
  localparam logic [1:0] LC = 2'd2;
`else
  localparam logic [1:0] LC = 2'd1;
`endif

  // Ring pointer advance; with a single-entry FIFO the pointer stays at 0.
  function automatic logic ptr_inc(input logic p);
    return (LC == 2'd1) ? 1'b0 : ~p;
  endfunction

  logic [DW-1:0] mem_q [DEPTH];
  logic          acc, rd_acc, pop;
  logic          rd_vld_q;
  logic [DW-1:0] rd_data_q;
  logic          arr_vld;
  logic [DW-1:0] arr_data;
  logic [DW-1:0] fifo_q [2];
  logic          wptr_q, wptr_d, rptr_q, rptr_d;
  logic [1:0]    fcnt_q, fcnt_d, cnt_q, cnt_d;
  logic          push, fpop;
  logic [DW-1:0] head;

  assign acc    = req_valid && req_ready;
  assign rd_acc = acc && !req_we;

  // Array access: byte-masked write or synchronous read, one per cycle.
  always_ff @(posedge clk) begin
    if (acc) begin
      if (req_we) begin
        for (int b = 0; b < BW; b++) begin
          if (req_be[b]) mem_q[req_addr][8*b +: 8] <= req_wdata[8*b +: 8];
        end
      end else begin
        rd_data_q <= mem_q[req_addr];
      end
    end
  end

  // Read-in-flight flag for the array output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) rd_vld_q <= 1'b0;
    else     rd_vld_q <= rd_acc;
  end

`ifdef RAM_OREG_EN
  logic          oreg_vld_q;
  logic [DW-1:0] oreg_data_q;

  // Output register stage data, loaded only when a read is returning.
  always_ff @(posedge clk) begin
    if (rd_vld_q) oreg_data_q <= rd_data_q;
  end

  // Output register stage valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) oreg_vld_q <= 1'b0;
    else     oreg_vld_q <= rd_vld_q;
  end

  assign arr_vld  = oreg_vld_q;
  assign arr_data = oreg_data_q;
`else
  assign arr_vld  = rd_vld_q;
  assign arr_data = rd_data_q;
`endif

  // Arriving data bypasses the FIFO when it is empty and the consumer takes it.
  assign push      = arr_vld && !((fcnt_q == 2'd0) && rsp_ready);
  assign fpop      = (fcnt_q != 2'd0) && rsp_ready;
  assign head      = (fcnt_q != 2'd0) ? fifo_q[rptr_q] : arr_data;
  assign rsp_valid = (fcnt_q != 2'd0) || arr_vld;
  assign rsp_rdata = rsp_valid ? head : '0;
  assign pop       = rsp_valid && rsp_ready;
  assign req_ready = (cnt_q < LC) || (pop && (cnt_q == LC));

  // Next-state for FIFO pointers/occupancy and the read credit counter.
  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = fpop ? ptr_inc(rptr_q) : rptr_q;
    fcnt_d = fcnt_q + {1'b0, push} - {1'b0, fpop};
    cnt_d  = cnt_q + {1'b0, rd_acc} - {1'b0, pop};
  end

  // Skid FIFO storage.
  always_ff @(posedge clk) begin
    if (push) fifo_q[wptr_q] <= arr_data;
  end

  // Control state; reset discards in-flight and queued responses.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= 1'b0;
      rptr_q <= 1'b0;
      fcnt_q <= 2'd0;
      cnt_q  <= 2'd0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      fcnt_q <= fcnt_d;
      cnt_q  <= cnt_d;
    end
  end

endmodule
